line_fetcher: RTL and testbench
===============================

# line_fetcher

Refill engine on the monitor-bypass side of the relational cache: consumes the request notifications emitted by the AXI read-trapping front end, fetches the corresponding cache line from main memory over an AXI4 master read channel, writes the beats into the shared line BRAM, then emits an availability notification carrying the same {offset, addr, id}. It is the producer of the BRAM contents and availability stream that the front end consumes, and it drives `monitor_bypass_ready` back to that front end.

## Interface
- C_S_AXI_ID_WIDTH, 1, width of the notification id field
- C_M_AXI_ADDR_WIDTH, 40, master read address width
- C_M_AXI_DATA_WIDTH, 128, master read data width; equals C_BRAM_DATA_WIDTH
- C_BRAM_DATA_WIDTH, 128, BRAM word width
- C_BRAM_ADDR_WIDTH, 32, BRAM word-address width
- QUEUE_LENGTH, 8, request FIFO depth (power of two)
- BEATS, 4, beats per cache line (power of two, ≥2)
- CHANNEL_ADDR_WIDTH, 34, line-address width (C_M_AXI_ADDR_WIDTH-6)
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low
- request_notification_addr / _id / _offset  in  CHANNEL_ADDR_WIDTH / C_S_AXI_ID_WIDTH / $clog2(BEATS)  requested line, id, critical beat
- request_notification_valid  in  1  single-cycle push strobe
- monitor_bypass_ready  out  1  FIFO not full
- availability_notification_addr / _id / _offset  out  as request  copy of served entry
- availability_notification_valid  out  1  one-cycle strobe, line in BRAM
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH; M_AXI_ARLEN out 8 (BEATS-1); M_AXI_ARSIZE out 3 ($clog2(C_M_AXI_DATA_WIDTH/8)); M_AXI_ARBURST out 2; M_AXI_ARID out 1 (0)
- M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA in C_M_AXI_DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RLAST in 1; M_AXI_RVALID in 1; M_AXI_RREADY out 1
- bram_clk out 1 (=S_AXI_ACLK); bram_rst out 1 (=~S_AXI_ARESETN); bram_en out 1 (constant 1)
- bram_we  out  C_BRAM_DATA_WIDTH/8  all-ones on write beat, else 0
- bram_addr  out  C_BRAM_ADDR_WIDTH  (line_addr*BEATS + beat), truncated
- bram_wrdata  out  C_BRAM_DATA_WIDTH  = M_AXI_RDATA
- fetch_error  out  1  sticky: non-OKAY RRESP or RLAST mismatch

## Operation
- FIFO of {offset, addr, id}; push when valid && !full; push while full is dropped (front end must not issue it). monitor_bypass_ready = !full from registered count; a pop in the same cycle does not raise it.
- FSM IDLE→AR when FIFO non-empty; AR: ARVALID=1, leave on ARREADY→DATA; DATA: RREADY=1, each RVALID write one BRAM word, beat counter ++ mod BEATS; after BEATS beats→NOTIFY; NOTIFY: availability_valid=1 with head entry, pop, →IDLE.
- ARADDR = {head_addr, 6'b0} zero-extended; beat index = (start + count) mod BEATS.
- RLAST not used for termination; RLAST≠(count==BEATS-1) or RRESP≠0 sets fetch_error; data still written, notification still sent.
- Reset (any time): FIFO empty, state IDLE; all outputs 0 except monitor_bypass_ready=1, bram_rst=1, bram_en=1, ARLEN/ARSIZE/ARBURST constants.

## Timing
- Push at edge 0 → ARVALID high from cycle 2.
- BRAM write combinational in the R-handshake cycle.
- Last beat at cycle t → availability_valid high cycle t+1 only; next ARVALID at t+3 earliest.
- One outstanding fetch; ARVALID held stable until ARREADY.

## Configuration
- LINE_FETCHER_WRAP_FETCH_EN defined: ARBURST=WRAP, ARADDR low bits = offset*(C_M_AXI_DATA_WIDTH/8), start = head_offset (critical-word-first).
- Undefined: ARBURST=INCR, start = 0. BRAM contents and notification identical in both.

## Structure
- Package line_fetcher_pkg: state enum, notification entry struct {offset, addr, id}, AXI burst/resp constants.
- One sub-module: notif_fifo (parametric sync FIFO, count, full/empty).

## Test plan
- Single request addr 0x12, off 0 → ARADDR 0x480, ARLEN 3; BRAM writes 0x48..0x4B; availability addr 0x12 one cycle.
- WRAP_EN, addr 0x12 off 2 → ARADDR 0x4A0, ARBURST 2; writes 0x4A,0x4B,0x48,0x49.
- 9 back-to-back pushes, ARREADY held low → ready falls after 8th; 9th dropped; all 8 served in order.
- RVALID gaps and ARREADY delay 5 cycles → no spurious writes; notify exactly t+1 after 4th beat.
- RRESP=2 on beat 1 → fetch_error=1, line still notified; stays 1 until reset.
- Reset asserted in DATA after beat 2 → outputs to reset values immediately, no notification; next request served cleanly.

Source files
------------

// File: rtl/line_fetcher_pkg.sv
// rtl/line_fetcher_pkg.sv - shared types and AXI constants for the line refill engine
package line_fetcher_pkg;

    // Refill sequencing: wait for work, issue address, collect beats, announce line
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AR     = 2'd1,
        ST_DATA   = 2'd2,
        ST_NOTIFY = 2'd3
    } state_t;

    localparam int LF_ADDR_W = 34;
    localparam int LF_ID_W   = 1;
    localparam int LF_OFF_W  = 2;

    // Queued request, packed in the same {offset, addr, id} order the FIFO stores
    typedef struct packed {
        logic [LF_OFF_W-1:0]  offset;
        logic [LF_ADDR_W-1:0] addr;
        logic [LF_ID_W-1:0]   id;
    } notif_entry_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/line_fetcher_notif_fifo.sv
// rtl/line_fetcher_notif_fifo.sv - synchronous request FIFO with occupancy count
module notif_fifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    // Storage array needs no reset; only entries below the count are ever read
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/line_fetcher.sv
// rtl/line_fetcher.sv - cache line refill engine (option macro: LINE_FETCHER_WRAP_FETCH_EN)
module line_fetcher
    import line_fetcher_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 40,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int C_BRAM_DATA_WIDTH  = 128,
    parameter int C_BRAM_ADDR_WIDTH  = 32,
    parameter int QUEUE_LENGTH       = 8,
    parameter int BEATS              = 4,
    parameter int CHANNEL_ADDR_WIDTH = 34
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [CHANNEL_ADDR_WIDTH-1:0]   request_notification_addr,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     request_notification_id,
    input  logic [$clog2(BEATS)-1:0]        request_notification_offset,
    input  logic                            request_notification_valid,
    output logic                            monitor_bypass_ready,
    output logic [CHANNEL_ADDR_WIDTH-1:0]   availability_notification_addr,
    output logic [C_S_AXI_ID_WIDTH-1:0]     availability_notification_id,
    output logic [$clog2(BEATS)-1:0]        availability_notification_offset,
    output logic                            availability_notification_valid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARID,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic                            bram_clk,
    output logic                            bram_rst,
    output logic                            bram_en,
    output logic [C_BRAM_DATA_WIDTH/8-1:0]  bram_we,
    output logic [C_BRAM_ADDR_WIDTH-1:0]    bram_addr,
    output logic [C_BRAM_DATA_WIDTH-1:0]    bram_wrdata,
    output logic                            fetch_error
);

    localparam int OFF_W      = $clog2(BEATS);
    localparam int ENTRY_W    = OFF_W + CHANNEL_ADDR_WIDTH + C_S_AXI_ID_WIDTH;
    localparam int SIZE_LOG2  = $clog2(C_M_AXI_DATA_WIDTH/8);
    localparam int LINE_SHIFT = $clog2(BEATS * (C_M_AXI_DATA_WIDTH/8));

    state_t                          r_state;
    state_t                          w_next_state;
    logic [OFF_W-1:0]                r_beat_cnt;
    logic                            r_fetch_error;
    logic [ENTRY_W-1:0]              w_head;
    logic [OFF_W-1:0]                w_head_offset;
    logic [CHANNEL_ADDR_WIDTH-1:0]   w_head_addr;
    logic [C_S_AXI_ID_WIDTH-1:0]     w_head_id;
    logic                            w_full;
    logic                            w_empty;
    logic                            w_pop;
    logic                            w_beat_hs;
    logic                            w_last_cnt;
    logic [OFF_W-1:0]                w_start;
    logic [OFF_W-1:0]                w_beat_idx;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_araddr;

    notif_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (QUEUE_LENGTH)
    ) u_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_push  (request_notification_valid),
        .i_data  ({request_notification_offset, request_notification_addr, request_notification_id}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_head_offset, w_head_addr, w_head_id} = w_head;

    assign w_beat_hs  = (r_state == ST_DATA) && M_AXI_RVALID;
    assign w_last_cnt = (r_beat_cnt == OFF_W'(BEATS-1));

`ifdef LINE_FETCHER_WRAP_FETCH_EN
    // Critical word first: memory returns the requested beat, then wraps
    assign w_start       = w_head_offset;
    assign w_araddr      = C_M_AXI_ADDR_WIDTH'({w_head_addr, {LINE_SHIFT{1'b0}}})
                         | (C_M_AXI_ADDR_WIDTH'(w_head_offset) << SIZE_LOG2);
    assign M_AXI_ARBURST = AXI_BURST_WRAP;
`else
    assign w_start       = '0;
    assign w_araddr      = C_M_AXI_ADDR_WIDTH'({w_head_addr, {LINE_SHIFT{1'b0}}});
    assign M_AXI_ARBURST = AXI_BURST_INCR;
`endif

    assign w_beat_idx = w_start + r_beat_cnt;

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= ST_IDLE;
        else                r_state <= w_next_state;
    end

    // Next state: termination counts beats, RLAST is only audited
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (!w_empty)                w_next_state = ST_AR;
            ST_AR:     if (M_AXI_ARREADY)           w_next_state = ST_DATA;
            ST_DATA:   if (w_beat_hs && w_last_cnt) w_next_state = ST_NOTIFY;
            ST_NOTIFY:                              w_next_state = ST_IDLE;
            default:                                w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded handshake and strobe outputs
    always_comb begin
        M_AXI_ARVALID                   = 1'b0;
        M_AXI_RREADY                    = 1'b0;
        availability_notification_valid = 1'b0;
        w_pop                           = 1'b0;
        case (r_state)
            ST_AR:     M_AXI_ARVALID = 1'b1;
            ST_DATA:   M_AXI_RREADY  = 1'b1;
            ST_NOTIFY: begin
                availability_notification_valid = 1'b1;
                w_pop                           = 1'b1;
            end
            default: ;
        endcase
    end

    // Beat counter restarts on every burst; wraps mod BEATS by width
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)         r_beat_cnt <= '0;
        else if (r_state != ST_DATA) r_beat_cnt <= '0;
        else if (w_beat_hs)          r_beat_cnt <= r_beat_cnt + 1'b1;
    end

    // Sticky error: bad response or RLAST on the wrong beat
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_fetch_error <= 1'b0;
        end else if (w_beat_hs && ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != w_last_cnt))) begin
            r_fetch_error <= 1'b1;
        end
    end

    assign monitor_bypass_ready = !w_full;
    assign fetch_error          = r_fetch_error;

    assign M_AXI_ARADDR = M_AXI_ARVALID ? w_araddr : '0;
    assign M_AXI_ARLEN  = 8'(BEATS-1);
    assign M_AXI_ARSIZE = 3'(SIZE_LOG2);
    assign M_AXI_ARID   = 1'b0;

    assign availability_notification_addr   = availability_notification_valid ? w_head_addr   : '0;
    assign availability_notification_id     = availability_notification_valid ? w_head_id     : '0;
    assign availability_notification_offset = availability_notification_valid ? w_head_offset : '0;

    assign bram_clk    = S_AXI_ACLK;
    assign bram_rst    = ~S_AXI_ARESETN;
    assign bram_en     = 1'b1;
    assign bram_we     = {(C_BRAM_DATA_WIDTH/8){w_beat_hs}};
    assign bram_addr   = w_beat_hs ? C_BRAM_ADDR_WIDTH'({w_head_addr, w_beat_idx}) : '0;
    assign bram_wrdata = M_AXI_RDATA;

endmodule

// File: tb/tb_line_fetcher.sv
// tb/tb_line_fetcher.sv - randomized bench for line_fetcher with a transaction-level reference model
module tb_line_fetcher;

    localparam int B  = 4;
    localparam int QL = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [33:0]  req_addr;
    logic         req_id;
    logic [1:0]   req_off;
    logic         req_valid;
    logic         mb_ready;
    logic [33:0]  av_addr;
    logic         av_id;
    logic [1:0]   av_off;
    logic         av_valid;
    logic [39:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arid;
    logic         arvalid;
    logic         arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         b_clk;
    logic         b_rst;
    logic         b_en;
    logic [15:0]  b_we;
    logic [31:0]  b_addr;
    logic [127:0] b_wrdata;
    logic         ferr;

    always #5 clk = ~clk;

    line_fetcher dut (
        .S_AXI_ACLK                       (clk),
        .S_AXI_ARESETN                    (rst_n),
        .request_notification_addr        (req_addr),
        .request_notification_id          (req_id),
        .request_notification_offset      (req_off),
        .request_notification_valid       (req_valid),
        .monitor_bypass_ready             (mb_ready),
        .availability_notification_addr   (av_addr),
        .availability_notification_id     (av_id),
        .availability_notification_offset (av_off),
        .availability_notification_valid  (av_valid),
        .M_AXI_ARADDR                     (araddr),
        .M_AXI_ARLEN                      (arlen),
        .M_AXI_ARSIZE                     (arsize),
        .M_AXI_ARBURST                    (arburst),
        .M_AXI_ARID                       (arid),
        .M_AXI_ARVALID                    (arvalid),
        .M_AXI_ARREADY                    (arready),
        .M_AXI_RDATA                      (rdata),
        .M_AXI_RRESP                      (rresp),
        .M_AXI_RLAST                      (rlast),
        .M_AXI_RVALID                     (rvalid),
        .M_AXI_RREADY                     (rready),
        .bram_clk                         (b_clk),
        .bram_rst                         (b_rst),
        .bram_en                          (b_en),
        .bram_we                          (b_we),
        .bram_addr                        (b_addr),
        .bram_wrdata                      (b_wrdata),
        .fetch_error                      (ferr)
    );

    typedef struct {
        logic [33:0] addr;
        logic        id;
        logic [1:0]  off;
        int          pcyc;
    } ent_t;

`ifdef LINE_FETCHER_WRAP_FETCH_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
    localparam bit         WRAP      = 1'b1;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
    localparam bit         WRAP      = 1'b0;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model
    ent_t q[$];
    bit   ar_done     = 0;
    int   beats       = 0;
    int   notify_at   = -1;
    int   last_notify = -100;
    bit   m_err       = 0;

    // memory slave
    int          s_left     = 0;
    logic [39:0] s_araddr   = '0;
    int          s_ar_cnt   = 0;
    int          s_ar_delay = 0;
    bit          ar_hold    = 0;
    int          gap_pct    = 0;
    int          delay_max  = 0;
    int          err_beat   = -1;

    // stimulus and observation logs
    bit          push_pend = 0;
    ent_t        pend;
    logic [39:0] ar_log[$];
    logic [31:0] wr_log[$];
    logic [33:0] av_log[$];

    function automatic logic [127:0] beat_data(logic [33:0] line, logic [1:0] idx);
        return {16'hC0DE, 14'd0, idx, line[31:0], ~line[31:0], {30'd0, idx} ^ 32'h5A5A5A5A};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_and_advance();
        int          ear;
        bit          exp_arv;
        bit          exp_rr;
        bit          exp_we;
        bit          exp_av;
        bit          push_ok;
        logic [1:0]  idx;
        logic [39:0] exp_ar;
        ear     = 0;
        exp_arv = 0;
        if (q.size() > 0) begin
            ear     = (q[0].pcyc + 2 > last_notify + 2) ? q[0].pcyc + 2 : last_notify + 2;
            exp_arv = !ar_done && (notify_at < 0) && (cyc >= ear);
        end
        exp_rr = ar_done && (beats < B);
        exp_we = exp_rr && rvalid;
        exp_av = (notify_at == cyc);

        check("ready", mb_ready, q.size() < QL);
        check("arvalid", arvalid, exp_arv);
        if (exp_arv) begin
            exp_ar = 40'({q[0].addr, 6'd0}) + (WRAP ? 40'(q[0].off) * 40'd16 : 40'd0);
            check("araddr", araddr, exp_ar);
            check("arburst", arburst, EXP_BURST);
            check("arlen", arlen, 8'd3);
        end
        check("rready", rready, exp_rr);
        check("bram_we", b_we, exp_we ? 16'hFFFF : 16'h0000);
        if (exp_we) begin
            idx = 2'((WRAP ? int'(q[0].off) : 0) + beats);
            check("bram_addr", b_addr, 32'({q[0].addr, idx}));
            check("bram_wrdata", b_wrdata, beat_data(q[0].addr, idx));
            wr_log.push_back(b_addr);
        end
        check("avail_valid", av_valid, exp_av);
        if (exp_av) begin
            check("avail_addr", av_addr, q[0].addr);
            check("avail_id", av_id, q[0].id);
            check("avail_off", av_off, q[0].off);
            av_log.push_back(av_addr);
        end
        check("fetch_error", ferr, m_err);

        // slave follows the DUT's actual handshakes
        if (arvalid && arready) begin
            s_left     = B;
            s_araddr   = araddr;
            s_ar_cnt   = 0;
            s_ar_delay = $urandom_range(delay_max, 0);
            ar_log.push_back(araddr);
        end else if (arvalid) begin
            s_ar_cnt++;
        end
        if (rvalid && rready && s_left > 0) s_left--;

        // model advances on its own expectations
        push_ok = req_valid && (q.size() < QL);
        if (exp_arv && arready) ar_done = 1;
        if (exp_we) begin
            if (rresp != 2'b00 || rlast != (beats == B-1)) m_err = 1;
            beats++;
            if (beats == B) notify_at = cyc + 1;
        end
        if (exp_av) begin
            void'(q.pop_front());
            last_notify = cyc;
            ar_done     = 0;
            beats       = 0;
            notify_at   = -1;
        end
        if (push_ok) begin
            pend.pcyc = cyc;
            q.push_back(pend);
        end
    endtask

    task automatic tick();
        int          k;
        logic [1:0]  idx;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = push_pend;
        req_addr  = pend.addr;
        req_id    = pend.id;
        req_off   = pend.off;
        arready   = !ar_hold && (s_ar_cnt >= s_ar_delay);
        if (s_left > 0 && $urandom_range(99, 0) >= gap_pct) begin
            k      = B - s_left;
            idx    = WRAP ? 2'(int'(s_araddr[5:4]) + k) : 2'(k);
            rvalid = 1'b1;
            rdata  = beat_data(s_araddr[39:6], idx);
            rlast  = (s_left == 1);
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = {$urandom, $urandom, $urandom, $urandom};
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
        @(negedge clk);
        if (rst_n) compare_and_advance();
        push_pend = 0;
    endtask

    task automatic push(logic [33:0] a, logic i, logic [1:0] o);
        pend.addr = a;
        pend.id   = i;
        pend.off  = o;
        push_pend = 1;
        tick();
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((q.size() > 0) && (n < budget)) begin
            tick();
            n++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ready"}, mb_ready, 1'b1);
        check({tag, "_arvalid"}, arvalid, 1'b0);
        check({tag, "_araddr"}, araddr, 40'd0);
        check({tag, "_arlen"}, arlen, 8'd3);
        check({tag, "_arsize"}, arsize, 3'd4);
        check({tag, "_arburst"}, arburst, EXP_BURST);
        check({tag, "_arid"}, arid, 1'b0);
        check({tag, "_rready"}, rready, 1'b0);
        check({tag, "_bram_we"}, b_we, 16'h0);
        check({tag, "_bram_addr"}, b_addr, 32'h0);
        check({tag, "_avail_valid"}, av_valid, 1'b0);
        check({tag, "_avail_addr"}, av_addr, 34'h0);
        check({tag, "_fetch_error"}, ferr, 1'b0);
        check({tag, "_bram_rst"}, b_rst, 1'b1);
        check({tag, "_bram_en"}, b_en, 1'b1);
    endtask

    task automatic model_reset();
        q.delete();
        ar_done     = 0;
        beats       = 0;
        notify_at   = -1;
        last_notify = -100;
        m_err       = 0;
        s_left      = 0;
        s_ar_cnt    = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w [4];
        int          n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_id    = 1'b0;
        req_off   = '0;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        pend      = '{addr: '0, id: 1'b0, off: '0, pcyc: 0};
        #1;
        check_reset_outputs("por");
        repeat (3) tick();
        #2 rst_n = 1'b1;
        repeat (2) tick();

        // single line, offset 0
        ar_log.delete(); wr_log.delete(); av_log.delete();
        push(34'h12, 1'b0, 2'd0);
        drain(100);
        check("t1_ar_count", ar_log.size(), 1);
        if (ar_log.size() > 0) check("t1_araddr", ar_log[0], 40'h480);
        check("t1_wr_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t1_wr_addr", wr_log[i], 32'h48 + 32'(i));
        check("t1_av_count", av_log.size(), 1);
        if (av_log.size() > 0) check("t1_av_addr", av_log[0], 34'h12);

        // single line, critical beat 2
        ar_log.delete(); wr_log.delete(); av_log.delete();
        push(34'h12, 1'b1, 2'd2);
        drain(100);
        if (WRAP) begin
            exp_w = '{32'h4A, 32'h4B, 32'h48, 32'h49};
            if (ar_log.size() > 0) check("t2_araddr", ar_log[0], 40'h4A0);
        end else begin
            exp_w = '{32'h48, 32'h49, 32'h4A, 32'h4B};
            if (ar_log.size() > 0) check("t2_araddr", ar_log[0], 40'h480);
        end
        check("t2_wr_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t2_wr_addr", wr_log[i], exp_w[i]);

        // nine back-to-back pushes with the address channel stalled
        av_log.delete();
        ar_hold = 1;
        for (int i = 0; i < 9; i++) push(34'h100 + 34'(i), 1'(i), 2'(i));
        check("t3_ready_full", mb_ready, 1'b0);
        repeat (3) tick();
        ar_hold = 0;
        drain(400);
        check("t3_av_count", av_log.size(), 8);
        for (int i = 0; i < 8 && i < av_log.size(); i++) check("t3_order", av_log[i], 34'h100 + 34'(i));

        // randomized traffic with beat gaps and address stalls
        gap_pct   = 30;
        delay_max = 4;
        for (int i = 0; i < 400; i++) begin
            if (mb_ready && $urandom_range(99, 0) < 40) begin
                push({2'($urandom), 32'($urandom)}, 1'($urandom), 2'($urandom));
            end else begin
                tick();
            end
        end
        drain(2000);

        // heavy beat gaps plus a five-cycle address stall
        gap_pct    = 50;
        delay_max  = 0;
        s_ar_delay = 5;
        push(34'h2_0000_0ABC, 1'b1, 2'd3);
        drain(200);

        // error response on beat 1
        gap_pct  = 0;
        err_beat = 1;
        av_log.delete();
        push(34'h777, 1'b0, 2'd1);
        drain(100);
        err_beat = -1;
        check("t6_fetch_error", ferr, 1'b1);
        check("t6_av_count", av_log.size(), 1);
        push(34'h778, 1'b0, 2'd0);
        drain(100);
        check("t6_error_sticky", ferr, 1'b1);

        // reset in the middle of a burst
        gap_pct = 20;
        av_log.delete();
        push(34'h3C, 1'b1, 2'd1);
        n = 0;
        while (!(ar_done && beats == 2) && n < 200) begin
            tick();
            n++;
        end
        check("t7_reached_beat2", beats, 2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        repeat (3) tick();
        check("t7_no_notify", av_log.size(), 0);
        #2 rst_n = 1'b1;
        tick();
        push(34'h3D, 1'b0, 2'd2);
        drain(100);
        check("t7_av_count", av_log.size(), 1);
        if (av_log.size() > 0) check("t7_av_addr", av_log[0], 34'h3D);
        check("t7_fetch_error", ferr, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
